// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_parser
// Purpose  : Byte-level frame parser placed behind the UART receiver.
//            Recognises SYNC, CMD, LEN, LEN payload bytes, CHK. Checks an
//            8-bit additive checksum over CMD+LEN+payload and buffers the
//            payload locally. A good frame is held for the command logic
//            until it is acknowledged.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous reset, active low
//            rx_data      - received byte
//            rx_valid     - one-cycle strobe qualifying rx_data
//            frame_ack    - consumer releases the held frame (HOLD only)
//            rd_addr      - payload buffer read address
//            rd_data      - payload byte at rd_addr, one cycle latency
//            frame_ready  - a complete, checksum-valid frame is held
//            frame_cmd    - CMD byte of the held frame
//            frame_len    - LEN of the held frame
//            err_chk      - one-cycle pulse on checksum mismatch
//            err_len      - one-cycle pulse when LEN exceeds MAX_LEN
//            err_timeout  - one-cycle pulse on inter-byte timeout abort
//            overrun      - one-cycle pulse when a byte is dropped in HOLD
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_parser #(
    parameter logic [7:0] SYNC    = 8'hAA,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    input  logic                           frame_ack,
    input  logic [$clog2(MAX_LEN)-1:0]     rd_addr,
    output logic [7:0]                     rd_data,
    output logic                           frame_ready,
    output logic [7:0]                     frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
    output logic                           err_chk,
    output logic                           err_len,
    output logic                           err_timeout,
    output logic                           overrun
);

    localparam int c_AW = $clog2(MAX_LEN);
    localparam int c_LW = $clog2(MAX_LEN + 1);
    localparam int c_TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]      c_MAX_LEN8 = 8'(MAX_LEN);
    localparam logic [c_LW-1:0] c_LEN_ONE  = c_LW'(1);
    localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_TMO_SAT  = c_TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_sum;
    logic [c_LW-1:0] r_len;
    logic [c_LW-1:0] r_idx;
    logic [c_TW-1:0] r_tmo;
    logic [7:0]      r_buf [MAX_LEN];

    logic w_active;
    logic w_tmo_hit;
    logic w_buf_wr;

    // Inter-byte timer only runs while a frame is being assembled.
    assign w_active  = (r_state == S_CMD) || (r_state == S_LEN) ||
                       (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // Abort on the idle cycle that brings the count up to TIMEOUT.
    assign w_tmo_hit = w_active && !rx_valid && (r_tmo == c_TMO_LAST);
    assign w_buf_wr  = (r_state == S_PAYLOAD) && rx_valid;

    // Payload storage carries no reset; contents are only meaningful in HOLD.
    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_buf[r_idx[c_AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'h00;
            r_sum       <= 8'h00;
            r_len       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            rd_data     <= 8'h00;
            frame_ready <= 1'b0;
            frame_cmd   <= 8'h00;
            frame_len   <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            rd_data     <= r_buf[rd_addr];

            if (w_active) begin
                if (rx_valid) begin
                    r_tmo <= '0;
                end else if (r_tmo != c_TMO_SAT) begin
                    r_tmo <= r_tmo + c_TMO_ONE;
                end
            end else begin
                r_tmo <= '0;
            end

            if (w_tmo_hit) begin
                err_timeout <= 1'b1;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_valid && (rx_data == SYNC)) begin
                            r_state <= S_CMD;
                        end
                    end

                    S_CMD: begin
                        if (rx_valid) begin
                            r_cmd   <= rx_data;
                            r_sum   <= rx_data;
                            r_state <= S_LEN;
                        end
                    end

                    S_LEN: begin
                        if (rx_valid) begin
                            if (rx_data > c_MAX_LEN8) begin
                                err_len <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_sum <= r_sum + rx_data;
                                r_len <= rx_data[c_LW-1:0];
                                r_idx <= '0;
                                r_state <= (rx_data == 8'h00) ? S_CHK : S_PAYLOAD;
                            end
                        end
                    end

                    S_PAYLOAD: begin
                        if (rx_valid) begin
                            r_sum <= r_sum + rx_data;
                            r_idx <= r_idx + c_LEN_ONE;
                            if ((r_idx + c_LEN_ONE) == r_len) begin
                                r_state <= S_CHK;
                            end
                        end
                    end

                    S_CHK: begin
                        if (rx_valid) begin
                            if (rx_data == r_sum) begin
                                frame_cmd   <= r_cmd;
                                frame_len   <= r_len;
                                frame_ready <= 1'b1;
                                r_state     <= S_HOLD;
                            end else begin
                                err_chk <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end

                    S_HOLD: begin
                        // Bytes arriving while a frame is held are lost;
                        // an ack in the same cycle is still honoured.
                        if (rx_valid) begin
                            overrun <= 1'b1;
                        end
                        if (frame_ack) begin
                            frame_ready <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
